// File: rtl/sync_capture_counter.sv
// -----------------------------------------------------------------------------
// sync_capture_counter
//
// Multi-channel synchronous event counter with snapshot capture. Every channel
// counts its own event pulse (already synchronised to clk) while the common
// count enable is high. A single-cycle capture strobe copies all counters into
// a holding register and restarts the counters in the same cycle, so no event
// is lost between consecutive windows. The snapshot is offered to a consumer
// with a valid/ready handshake; a capture that cannot be delivered because the
// previous snapshot is still pending sets a sticky overrun flag.
//
// Parameters:
//   width     bits per channel counter (>= 2)
//   channels  number of independent counters (>= 1)
//   saturate  0: wrap from 2^width-1 to 0, 1: hold at 2^width-1
//
// Ports:
//   clk       clock; every register updates on its rising edge
//   clr       synchronous, active-high reset; overrides all other inputs
//   clkEn     count enable, common to all channels
//   evIn      per-channel event pulse, one count per high cycle
//   cap       capture strobe, single cycle
//   cntOut    holding register; channel i at bits [i*width +: width]
//   outValid  holding register contains an unconsumed snapshot
//   outReady  consumer accepts the snapshot while outValid is high
//   overrun   sticky; a capture was dropped because the snapshot was pending
//   cntOvf    (only with CNT_OVF_FLAG_EN) per-channel wrap/saturation flag,
//             captured alongside cntOut
//
// Optional feature: define CNT_OVF_FLAG_EN to add the cntOvf output and the
// per-channel overflow flag logic. Without it the port and logic are absent
// and all other behaviour is identical.
//
// All outputs come straight from registers; there is no combinational path
// from any input to any output.
// -----------------------------------------------------------------------------
module sync_capture_counter #(
  parameter int unsigned width    = 16,
  parameter int unsigned channels = 1,
  parameter bit          saturate = 1'b0
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic                      clkEn,
  input  logic [channels-1:0]       evIn,
  input  logic                      cap,
  output logic [channels*width-1:0] cntOut,
  output logic                      outValid,
  input  logic                      outReady,
  output logic                      overrun
`ifdef CNT_OVF_FLAG_EN
  ,
  output logic [channels-1:0]       cntOvf
`endif
);

  typedef logic [width-1:0] cnt_t;

  localparam cnt_t CNT_MAX = '1;
  localparam cnt_t CNT_ONE = cnt_t'(1);

  // Live counters and their next values.
  cnt_t cnt_q [channels];
  cnt_t cnt_d [channels];

  // Per-channel qualified event and "counter sits at its top value".
  logic [channels-1:0] inc;
  logic [channels-1:0] at_max;

  // Pre-edge counter values packed in the output layout.
  logic [channels*width-1:0] snap;

  // Handshake decode.
  logic load;     // holding register takes a new snapshot this edge
  logic xfer;     // consumer takes the current snapshot this edge
  logic dropped;  // capture arrives while the old snapshot is still pending

`ifdef CNT_OVF_FLAG_EN
  logic [channels-1:0] ovf_q;    // live per-window overflow flags
  logic [channels-1:0] ovf_d;
  logic [channels-1:0] ovf_evt;  // wrap or saturation happening this cycle
`endif

  // ---------------------------------------------------------------------------
  // Counter next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path through
    // the block leaves it unassigned, which would otherwise infer a latch.
    inc    = {channels{clkEn}} & evIn;
    at_max = '0;
    snap   = '0;
    for (int i = 0; i < channels; i++) begin
      cnt_d[i]  = cnt_q[i];
      at_max[i] = (cnt_q[i] == CNT_MAX);
      snap[i*width +: width] = cnt_q[i];

      if (cap) begin
        // The capture-cycle event belongs to the new window, so the counter
        // restarts at 1 rather than 0 when an event coincides with capture.
        cnt_d[i] = inc[i] ? CNT_ONE : '0;
      end else if (inc[i]) begin
        if (at_max[i]) begin
          cnt_d[i] = saturate ? CNT_MAX : '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

`ifdef CNT_OVF_FLAG_EN
  // ---------------------------------------------------------------------------
  // Overflow flags: a qualifying event while the counter is at its top value is
  // a wrap (saturate=0) or a saturation hit (saturate=1). Capture starts a new
  // window, so the live flag only keeps an event that falls in that very cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    ovf_evt = inc & at_max;
    ovf_d   = cap ? ovf_evt : (ovf_q | ovf_evt);
  end
`endif

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  always_comb begin
    xfer    = outValid & outReady;
    load    = cap & (~outValid | outReady);
    dropped = cap & outValid & ~outReady;
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (clr) begin
      // NOTE: the holding register is reset too, because cntOut is visible to
      // the consumer and must read 0 after clr, not a stale snapshot.
      for (int i = 0; i < channels; i++) begin
        cnt_q[i] <= '0;
      end
      cntOut   <= '0;
      outValid <= 1'b0;
      overrun  <= 1'b0;
`ifdef CNT_OVF_FLAG_EN
      ovf_q    <= '0;
      cntOvf   <= '0;
`endif
    end else begin
      for (int i = 0; i < channels; i++) begin
        cnt_q[i] <= cnt_d[i];
      end

      // A load wins over a transfer: when both happen the new snapshot
      // replaces the one being consumed and outValid stays high.
      if (load) begin
        cntOut   <= snap;
        outValid <= 1'b1;
      end else if (xfer) begin
        outValid <= 1'b0;
      end

      if (dropped) begin
        overrun <= 1'b1;
      end

`ifdef CNT_OVF_FLAG_EN
      ovf_q <= ovf_d;
      if (load) begin
        cntOvf <= ovf_q;
      end
`endif
    end
  end

endmodule

// File: tb/tb_sync_capture_counter.sv
// -----------------------------------------------------------------------------
// tb_sync_capture_counter
//
// Self-checking bench for sync_capture_counter. Three instances share the
// control inputs:
//   dut_a  width=8, channels=2, saturate=0  (main scoreboard target)
//   dut_b  width=4, channels=1, saturate=0  (wrap behaviour)
//   dut_c  width=4, channels=1, saturate=1  (saturation behaviour)
// A small reference model of dut_a pushes the expected snapshot into a queue
// whenever a capture is accepted; the entry is compared while it is held and
// popped when the consumer takes it.
// -----------------------------------------------------------------------------
module tb_sync_capture_counter;

  logic        clk;
  logic        clr;
  logic        clkEn;
  logic [1:0]  ev_a;
  logic [0:0]  ev_4;
  logic        cap;
  logic        outReady;

  logic [15:0] a_cnt;
  logic        a_valid;
  logic        a_ovr;
  logic [3:0]  b_cnt;
  logic        b_valid;
  logic        b_ovr;
  logic [3:0]  c_cnt;
  logic        c_valid;
  logic        c_ovr;
`ifdef CNT_OVF_FLAG_EN
  logic [1:0]  a_ovf;
  logic [0:0]  b_ovf;
  logic [0:0]  c_ovf;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model of dut_a.
  logic [7:0]  m_cnt [2];
  logic        m_valid;
  logic        m_ovr;
  logic [15:0] exp_q [$];

  sync_capture_counter #(.width(8), .channels(2), .saturate(1'b0)) dut_a (
    .clk      (clk),
    .clr      (clr),
    .clkEn    (clkEn),
    .evIn     (ev_a),
    .cap      (cap),
    .cntOut   (a_cnt),
    .outValid (a_valid),
    .outReady (outReady),
    .overrun  (a_ovr)
`ifdef CNT_OVF_FLAG_EN
    ,
    .cntOvf   (a_ovf)
`endif
  );

  sync_capture_counter #(.width(4), .channels(1), .saturate(1'b0)) dut_b (
    .clk      (clk),
    .clr      (clr),
    .clkEn    (clkEn),
    .evIn     (ev_4),
    .cap      (cap),
    .cntOut   (b_cnt),
    .outValid (b_valid),
    .outReady (outReady),
    .overrun  (b_ovr)
`ifdef CNT_OVF_FLAG_EN
    ,
    .cntOvf   (b_ovf)
`endif
  );

  sync_capture_counter #(.width(4), .channels(1), .saturate(1'b1)) dut_c (
    .clk      (clk),
    .clr      (clr),
    .clkEn    (clkEn),
    .evIn     (ev_4),
    .cap      (cap),
    .cntOut   (c_cnt),
    .outValid (c_valid),
    .outReady (outReady),
    .overrun  (c_ovr)
`ifdef CNT_OVF_FLAG_EN
    ,
    .cntOvf   (c_ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge, advance the model, let the
  // rising edge happen, and compare dut_a against the model at the next
  // falling edge.
  task automatic step(input logic r, input logic en, input logic [1:0] ev,
                      input logic c, input logic rdy, input logic e4);
    logic        ld;
    logic        inc;
    logic [15:0] got_exp;
    clr      = r;
    clkEn    = en;
    ev_a     = ev;
    cap      = c;
    outReady = rdy;
    ev_4     = e4;

    if (r) begin
      m_cnt[0] = '0;
      m_cnt[1] = '0;
      m_valid  = 1'b0;
      m_ovr    = 1'b0;
      exp_q.delete();
    end else begin
      ld = c && (!m_valid || rdy);
      if (m_valid && rdy) begin
        got_exp = exp_q.pop_front();
        check("xfer_data", a_cnt, got_exp);
      end
      if (ld) exp_q.push_back({m_cnt[1], m_cnt[0]});
      if (c && m_valid && !rdy) m_ovr = 1'b1;
      m_valid = ld || (m_valid && !rdy);
      for (int i = 0; i < 2; i++) begin
        inc = en && ev[i];
        if (c) m_cnt[i] = inc ? 8'd1 : 8'd0;
        else if (inc) m_cnt[i] = m_cnt[i] + 8'd1;
      end
    end

    @(posedge clk);
    @(negedge clk);

    check("valid", a_valid, m_valid);
    check("overrun", a_ovr, m_ovr);
    if (m_valid && exp_q.size() > 0) check("hold_data", a_cnt, exp_q[0]);
  endtask

  initial begin
    clr = 1'b1; clkEn = 1'b0; ev_a = '0; ev_4 = '0; cap = 1'b0; outReady = 1'b0;
    m_cnt[0] = '0; m_cnt[1] = '0; m_valid = 1'b0; m_ovr = 1'b0;

    // Reset state.
    step(1, 0, 2'b00, 0, 0, 0);
    step(1, 0, 2'b00, 0, 0, 0);
    check("rst_a_cnt", a_cnt, 0);
    check("rst_a_valid", a_valid, 0);
    check("rst_a_ovr", a_ovr, 0);
    check("rst_b_cnt", b_cnt, 0);
    check("rst_c_valid", c_valid, 0);

    // 10 events on channel 0, then capture with outReady low.
    for (int i = 0; i < 10; i++) step(0, 1, 2'b01, 0, 0, 0);
    step(0, 1, 2'b00, 1, 0, 0);
    check("t1_valid", a_valid, 1);
    check("t1_cnt", a_cnt, 16'h000A);
    step(0, 1, 2'b00, 0, 1, 0);
    check("t1_drained", a_valid, 0);

    // Capture coinciding with events on both channels after 5 counts.
    for (int i = 0; i < 5; i++) step(0, 1, 2'b11, 0, 0, 0);
    step(0, 1, 2'b11, 1, 0, 0);
    check("t2_first", a_cnt, 16'h0505);
    step(0, 1, 2'b00, 0, 1, 0);
    step(0, 1, 2'b00, 1, 0, 0);
    check("t2_carry", a_cnt, 16'h0101);
    step(0, 1, 2'b00, 0, 1, 0);

    // Count enable low: events must be ignored.
    for (int i = 0; i < 3; i++) step(0, 0, 2'b11, 0, 0, 0);
    step(0, 0, 2'b00, 1, 0, 0);
    check("t_noen", a_cnt, 16'h0000);
    step(0, 0, 2'b00, 0, 1, 0);

    // Overrun: two captures three cycles apart, outReady low throughout.
    for (int i = 0; i < 4; i++) step(0, 1, 2'b01, 0, 0, 0);
    step(0, 1, 2'b00, 1, 0, 0);
    step(0, 1, 2'b10, 0, 0, 0);
    step(0, 1, 2'b10, 0, 0, 0);
    step(0, 1, 2'b00, 1, 0, 0);
    check("t3_ovr", a_ovr, 1);
    check("t3_kept", a_cnt, 16'h0004);
    step(0, 1, 2'b00, 0, 1, 0);
    check("t3_valid_low", a_valid, 0);
    check("t3_ovr_sticky", a_ovr, 1);
    step(0, 1, 2'b00, 0, 1, 0);
    check("t3_no_second", a_valid, 0);

    // Capture with simultaneous transfer.
    step(1, 0, 2'b00, 0, 0, 0);
    for (int i = 0; i < 2; i++) step(0, 1, 2'b11, 0, 0, 0);
    step(0, 1, 2'b00, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 2'b10, 0, 0, 0);
    step(0, 1, 2'b00, 1, 1, 0);
    check("t4_valid", a_valid, 1);
    check("t4_ovr", a_ovr, 0);
    check("t4_new", a_cnt, 16'h0300);
    step(0, 1, 2'b00, 0, 1, 0);

    // Wrap vs saturate, 17 events on 4-bit counters.
    step(1, 0, 2'b00, 0, 0, 0);
    for (int i = 0; i < 17; i++) step(0, 1, 2'b10, 0, 0, 1);
    step(0, 1, 2'b00, 1, 0, 0);
    check("t5_wrap", b_cnt, 4'd1);
    check("t5_sat", c_cnt, 4'd15);
    check("t5_b_valid", b_valid, 1);
    check("t5_c_ovr", c_ovr, 0);
`ifdef CNT_OVF_FLAG_EN
    check("t5_ovf_wrap", b_ovf, 1);
    check("t5_ovf_sat", c_ovf, 1);
    check("t5_ovf_none", a_ovf, 0);
`endif
    step(0, 1, 2'b00, 0, 1, 0);
`ifdef CNT_OVF_FLAG_EN
    step(0, 1, 2'b00, 1, 0, 0);
    check("t5_ovf_cleared", b_ovf, 0);
    step(0, 1, 2'b00, 0, 1, 0);
`endif

    // Reset mid-handshake with nonzero counters and a capture.
    for (int i = 0; i < 3; i++) step(0, 1, 2'b11, 0, 0, 1);
    step(0, 1, 2'b00, 1, 0, 0);
    step(0, 1, 2'b11, 0, 0, 1);
    step(0, 1, 2'b11, 0, 0, 1);
    step(1, 1, 2'b11, 1, 0, 1);
    check("t6_cnt", a_cnt, 0);
    check("t6_valid", a_valid, 0);
    check("t6_ovr", a_ovr, 0);
    check("t6_b_cnt", b_cnt, 0);
    check("t6_b_valid", b_valid, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 2'b01, 0, 0, 0);
    step(0, 1, 2'b00, 1, 0, 0);
    check("t6_resume", a_cnt, 16'h0003);
    step(0, 1, 2'b00, 0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
